// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the shared seven-segment display controller
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } share_state_t;

   localparam int NUM_DIGITS = 6;
   localparam int DIGIT_W    = 3;
   localparam int SEG_W      = 7;

   localparam logic [NUM_DIGITS-1:0] ENB_ALL_OFF = 6'b111111;
   localparam logic [DIGIT_W-1:0]    LAST_DIGIT  = 3'(NUM_DIGITS - 1);

endpackage

// File: rtl/disp_scan_timer.sv
// rtl/disp_scan_timer.sv - slot divider and digit counter producing slot and frame boundaries
module disp_scan_timer
   import disp_pkg::*;
#(
   parameter int SCAN_DIV = 5000,
   parameter int DIV_W    = $clog2(SCAN_DIV)
) (
   input  logic               clk,
   input  logic               rst,
   output logic [DIV_W-1:0]   div_cnt,
   output logic [DIGIT_W-1:0] digit,
   output logic               slot_end,
   output logic               frame_end
);

   assign slot_end  = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign frame_end = slot_end && (digit == LAST_DIGIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         digit   <= '0;
      end else if (slot_end) begin
         div_cnt <= '0;
         digit   <= (digit == LAST_DIGIT) ? '0 : digit + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/disp_share_ctrl.sv
// rtl/disp_share_ctrl.sv - round-robin time-shared six-digit display scanner with dwell limits
// Optional DISP_SHARE_BLANK_EN blanks all digits for the first two cycles of every slot.
module disp_share_ctrl
   import disp_pkg::*;
#(
   parameter int SCAN_DIV   = 5000,
   parameter int MIN_FRAMES = 20,
   parameter int MAX_FRAMES = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [41:0] i_bg_seg,
   input  logic [5:0]  i_bg_dp,
   input  logic [1:0]  i_req,
   input  logic [41:0] i_req0_seg,
   input  logic [41:0] i_req1_seg,
   input  logic [5:0]  i_req0_dp,
   input  logic [5:0]  i_req1_dp,
   output logic [1:0]  o_gnt,
   output logic        o_frame,
   output logic [6:0]  o_seg,
   output logic        o_seg_dp,
   output logic [5:0]  o_seg_enb
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int FRM_W = $clog2(MAX_FRAMES + 1);

   logic [DIV_W-1:0]   div_cnt;
   logic [DIGIT_W-1:0] digit;
   logic               slot_end;
   logic               frame_end;

   share_state_t state, state_nxt;
   logic [FRM_W-1:0] frm_cnt, frm_nxt, frm_inc;
   logic             rr, rr_nxt;
   logic             release_x, preempt_x;

   logic [41:0] src_seg;
   logic [5:0]  src_dp;
   logic [5:0]  enb_scan;

   disp_scan_timer #(
      .SCAN_DIV (SCAN_DIV),
      .DIV_W    (DIV_W)
   ) u_scan_timer (
      .clk       (clk),
      .rst       (rst),
      .div_cnt   (div_cnt),
      .digit     (digit),
      .slot_end  (slot_end),
      .frame_end (frame_end)
   );

   // Saturates at MAX_FRAMES so a long uncontested grant cannot wrap the count.
   assign frm_inc = (frm_cnt == FRM_W'(MAX_FRAMES)) ? frm_cnt : frm_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         frm_cnt <= '0;
         rr      <= 1'b0;
      end else begin
         state   <= state_nxt;
         frm_cnt <= frm_nxt;
         rr      <= rr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      frm_nxt   = frm_cnt;
      rr_nxt    = rr;
      release_x = 1'b0;
      preempt_x = 1'b0;
      if (frame_end) begin
         case (state)
            IDLE: begin
               if (i_req[0] && (!i_req[1] || !rr)) begin
                  state_nxt = G0;
                  rr_nxt    = 1'b1;
                  frm_nxt   = '0;
               end else if (i_req[1]) begin
                  state_nxt = G1;
                  rr_nxt    = 1'b0;
                  frm_nxt   = '0;
               end
            end
            G0: begin
               frm_nxt   = frm_inc;
               release_x = !i_req[0] && (frm_inc >= FRM_W'(MIN_FRAMES));
               preempt_x = i_req[1] && (frm_inc >= FRM_W'(MAX_FRAMES));
               if (release_x || preempt_x) begin
                  frm_nxt = '0;
                  if (i_req[1]) begin
                     state_nxt = G1;
                     rr_nxt    = 1'b0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            G1: begin
               frm_nxt   = frm_inc;
               release_x = !i_req[1] && (frm_inc >= FRM_W'(MIN_FRAMES));
               preempt_x = i_req[0] && (frm_inc >= FRM_W'(MAX_FRAMES));
               if (release_x || preempt_x) begin
                  frm_nxt = '0;
                  if (i_req[0]) begin
                     state_nxt = G0;
                     rr_nxt    = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               frm_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      case (state)
         G0:      begin src_seg = i_req0_seg; src_dp = i_req0_dp; end
         G1:      begin src_seg = i_req1_seg; src_dp = i_req1_dp; end
         default: begin src_seg = i_bg_seg;   src_dp = i_bg_dp;   end
      endcase
   end

   always_comb begin
      o_seg    = src_seg[6:0];
      o_seg_dp = src_dp[0];
      enb_scan = 6'b111110;
      case (digit)
         3'd1: begin o_seg = src_seg[13:7];  o_seg_dp = src_dp[1]; enb_scan = 6'b111101; end
         3'd2: begin o_seg = src_seg[20:14]; o_seg_dp = src_dp[2]; enb_scan = 6'b111011; end
         3'd3: begin o_seg = src_seg[27:21]; o_seg_dp = src_dp[3]; enb_scan = 6'b110111; end
         3'd4: begin o_seg = src_seg[34:28]; o_seg_dp = src_dp[4]; enb_scan = 6'b101111; end
         3'd5: begin o_seg = src_seg[41:35]; o_seg_dp = src_dp[5]; enb_scan = 6'b011111; end
         default: ;
      endcase
   end

`ifdef DISP_SHARE_BLANK_EN
   assign o_seg_enb = (div_cnt < DIV_W'(2)) ? ENB_ALL_OFF : enb_scan;
`else
   assign o_seg_enb = enb_scan;
`endif

   assign o_gnt   = {state == G1, state == G0};
   assign o_frame = frame_end;

endmodule

// File: tb/tb_disp_share_ctrl.sv
// tb/tb_disp_share_ctrl.sv - directed self-checking bench for disp_share_ctrl (SCAN_DIV=4, MIN=2, MAX=4)
module tb_disp_share_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [41:0] i_bg_seg   = 42'h1F2_E3D4_C5B6;
   logic [5:0]  i_bg_dp    = 6'b101001;
   logic [1:0]  i_req      = 2'b00;
   logic [41:0] i_req0_seg = 42'h0A5_5A3C_C3F0;
   logic [41:0] i_req1_seg = 42'h2CB_7D19_E60F;
   logic [5:0]  i_req0_dp  = 6'b010110;
   logic [5:0]  i_req1_dp  = 6'b110011;
   logic [1:0]  o_gnt;
   logic        o_frame;
   logic [6:0]  o_seg;
   logic        o_seg_dp;
   logic [5:0]  o_seg_enb;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   disp_share_ctrl #(
      .SCAN_DIV   (4),
      .MIN_FRAMES (2),
      .MAX_FRAMES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_bg_seg   (i_bg_seg),
      .i_bg_dp    (i_bg_dp),
      .i_req      (i_req),
      .i_req0_seg (i_req0_seg),
      .i_req1_seg (i_req1_seg),
      .i_req0_dp  (i_req0_dp),
      .i_req1_dp  (i_req1_dp),
      .o_gnt      (o_gnt),
      .o_frame    (o_frame),
      .o_seg      (o_seg),
      .o_seg_dp   (o_seg_dp),
      .o_seg_enb  (o_seg_enb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   function automatic logic [5:0] exp_enb(input int c);
      int d;
      d = (c / 4) % 6;
`ifdef DISP_SHARE_BLANK_EN
      if ((c % 4) < 2) return 6'b111111;
`endif
      return ~(6'b000001 << d);
   endfunction

   function automatic logic [6:0] slice(input logic [41:0] v, input int c);
      int d;
      d = (c / 4) % 6;
      return v[7*d +: 7];
   endfunction

   initial begin
      // Reset state and idle scan over two frames
      do_reset();
      check("rst_gnt", o_gnt, 2'b00);
      check("rst_frame", o_frame, 1'b0);
      for (int c = 0; c < 48; c++) begin
         run_to(c);
         check($sformatf("idle_enb_c%0d", c), o_seg_enb, exp_enb(c));
         check($sformatf("idle_seg_c%0d", c), o_seg, slice(i_bg_seg, c));
         check($sformatf("idle_dp_c%0d", c), o_seg_dp, i_bg_dp[(c/4)%6]);
         check($sformatf("idle_frame_c%0d", c), o_frame, (c % 24) == 23);
         check($sformatf("idle_gnt_c%0d", c), o_gnt, 2'b00);
      end

      // Single grant and minimum dwell after the request drops
      do_reset();
      run_to(5);
      i_req = 2'b01;
      run_to(23);
      check("single_gnt_c23", o_gnt, 2'b00);
      run_to(24);
      check("single_gnt_c24", o_gnt, 2'b01);
      check("single_seg_c24", o_seg, i_req0_seg[6:0]);
      check("single_dp_c24", o_seg_dp, i_req0_dp[0]);
      run_to(30);
      i_req = 2'b00;
      run_to(71);
      check("dwell_gnt_c71", o_gnt, 2'b01);
      check("dwell_seg_c71", o_seg, i_req0_seg[41:35]);
      run_to(72);
      check("dwell_gnt_c72", o_gnt, 2'b00);
      check("dwell_seg_c72", o_seg, i_bg_seg[6:0]);

      // Preemption at MAX_FRAMES and round-robin hand-back
      i_req = 2'b11;
      do_reset();
      run_to(23);
      check("pre_gnt_c23", o_gnt, 2'b00);
      run_to(24);
      check("pre_gnt_c24", o_gnt, 2'b01);
      run_to(119);
      check("pre_gnt_c119", o_gnt, 2'b01);
      run_to(120);
      check("pre_gnt_c120", o_gnt, 2'b10);
      check("pre_seg_c120", o_seg, i_req1_seg[6:0]);
      check("pre_dp_c120", o_seg_dp, i_req1_dp[0]);
      run_to(215);
      check("rr_gnt_c215", o_gnt, 2'b10);
      run_to(216);
      check("rr_gnt_c216", o_gnt, 2'b01);

      // Reset in the middle of a grant
      i_req = 2'b01;
      do_reset();
      run_to(50);
      check("mid_gnt_c50", o_gnt, 2'b01);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_gnt_after", o_gnt, 2'b00);
      check("mid_enb_after", o_seg_enb, exp_enb(0));
      check("mid_seg_after", o_seg, i_bg_seg[6:0]);
      for (int k = 0; k < 23; k++) begin
         check($sformatf("mid_frame_k%0d", k), o_frame, 1'b0);
         step();
      end
      check("mid_frame_k23", o_frame, 1'b1);
      i_req = 2'b00;

      // Request rising on the frame_end cycle is honoured at that boundary
      do_reset();
      run_to(23);
      i_req = 2'b10;
      check("edge_frame_c23", o_frame, 1'b1);
      run_to(24);
      check("edge_gnt_c24", o_gnt, 2'b10);
      check("edge_seg_c24", o_seg, i_req1_seg[6:0]);
      i_req = 2'b00;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
